stochastic_best_gain_finder: RTL and testbench
==============================================

STOCHASTIC_BEST_GAIN_FINDER -- requirements
Module: stochastic_best_gain_finder

Interface
REQ-001 Parameter MAXIMUM_BIT_WIDTH_OF_VARIABLES_INDEX, 2, log2 of candidate count; N = 2**MAXIMUM_BIT_WIDTH_OF_VARIABLES_INDEX.
REQ-002 Parameter GAIN_WIDTH, 8, width of signed two's-complement gain.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 in_clk  input  1  clock; all state updates on rising edge.
REQ-005 in_reset_n  input  1  asynchronous active-low reset.
REQ-006 in_enable  input  1  find-best-gain enable from the stochastic control unit; level, held for the whole search.
REQ-007 in_variables_enable  input  N  per-variable candidate mask; bit i set means variable i takes part.
REQ-008 in_gain  input  GAIN_WIDTH  signed gain of the variable addressed by out_gain_read_index, valid combinationally in the same cycle.
REQ-009 out_gain_read_index  output  MAXIMUM_BIT_WIDTH_OF_VARIABLES_INDEX  index currently scanned.
REQ-010 out_best_variable_index  output  MAXIMUM_BIT_WIDTH_OF_VARIABLES_INDEX  index of winning variable.
REQ-011 out_best_gain  output  GAIN_WIDTH  signed gain of winner.
REQ-012 out_found  output  1  at least one enabled variable was scanned.
REQ-013 out_done  output  1  result valid; drives the control unit's in_local_done.

Function
REQ-014 FSM states: IDLE, SCAN, DONE; all outputs registered.
REQ-015 IDLE: in_enable=1 at an edge -> SCAN, scan index=0, best index/gain/found cleared; else stay.
REQ-016 SCAN, each edge: if in_variables_enable[idx]=1 and (found=0 or in_gain > best gain, signed strict) -> best index<=idx, best gain<=in_gain, found<=1.
REQ-017 Ties: strict compare keeps the lowest index.
REQ-018 SCAN: idx increments by 1 per edge; edge evaluating idx=N-1 -> DONE and out_done<=1; idx does not wrap into another scan.
REQ-019 Latency: out_done rises exactly N edges after the acceptance edge (N+1 edges after in_enable first sampled high in IDLE).
REQ-020 DONE: outputs held stable, out_done=1 while in_enable=1; in_enable=0 -> IDLE, out_done<=0, results held until next acceptance.
REQ-021 in_enable=0 during SCAN -> abort to IDLE; best index, gain, found cleared; out_done stays 0.
REQ-022 Mask all-zero: scan still runs N cycles; done with found=0, index=0, gain=0.
REQ-023 Mask and in_gain are sampled per scan cycle; mask changes mid-scan affect only unscanned indices.
REQ-024 Most-negative gain (-2**(GAIN_WIDTH-1)) is a legal value and can win.
REQ-025 out_gain_read_index equals scan index in SCAN, 0 in IDLE and DONE.

Reset
REQ-026 in_reset_n=0 forces, without waiting for a clock edge, state=IDLE and all outputs/counters to 0.
REQ-027 Reset asserted mid-SCAN or in DONE discards the search; after release a new search requires in_enable sampled high in IDLE.

Structure
REQ-028 Shared package holds FSM state encodings (IDLE/SCAN/DONE, 2-bit) and default widths for variable index and gain.
REQ-029 One sub-module is natural: stochastic_gain_compare (combinational signed update decision: enable bit, found, in_gain, best gain -> update).
REQ-030 Target 120-400 lines RTL; no memories inside; gain storage stays external.

Verification (N=4, GAIN_WIDTH=8)
REQ-031 Mask 4'b1111, gains {3,-2,7,5} -> out_done after 4 edges post-accept, index=2, gain=7, found=1.
REQ-032 Mask 4'b1111, gains {5,5,1,5} -> index=0, gain=5 (tie keeps lowest).
REQ-033 Mask 4'b1010, gains {9,-4,9,-1} -> index=3, gain=-1; gain -128 alone enabled -> wins with -128.
REQ-034 Mask 4'b0000 -> out_done=1, found=0, index=0, gain=0.
REQ-035 in_enable dropped after 2 SCAN edges -> IDLE, out_done never rises, outputs 0; re-enable gives fresh correct result.
REQ-036 in_reset_n pulsed low between edges while in DONE -> all outputs 0 before next edge; in_enable held high then restarts search.

Source files
------------

// File: rtl/stochastic_best_gain_finder_pkg.sv
// Shared definitions for the best-gain search block: FSM state encoding and default widths.
package stochastic_best_gain_finder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEFAULT_INDEX_WIDTH = 2;
   localparam int DEFAULT_GAIN_WIDTH  = 8;

endpackage : stochastic_best_gain_finder_pkg

// File: rtl/stochastic_gain_compare.sv
// Combinational decision on whether the scanned variable becomes the new best candidate.
module stochastic_gain_compare
   import stochastic_best_gain_finder_pkg::*;
#(
   parameter int GAIN_WIDTH = DEFAULT_GAIN_WIDTH
) (
   input  logic                         enable_bit_i,
   input  logic                         found_i,
   input  logic signed [GAIN_WIDTH-1:0] gain_i,
   input  logic signed [GAIN_WIDTH-1:0] best_gain_i,
   output logic                         update_o
);

   // Strict greater-than keeps the earliest (lowest) index on ties.
   assign update_o = enable_bit_i && (!found_i || (gain_i > best_gain_i));

endmodule : stochastic_gain_compare

// File: rtl/stochastic_best_gain_finder.sv
// Scans N candidate gains one per cycle and reports the enabled variable with the largest signed gain.
module stochastic_best_gain_finder
   import stochastic_best_gain_finder_pkg::*;
#(
   parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLES_INDEX = DEFAULT_INDEX_WIDTH,
   parameter int GAIN_WIDTH                          = DEFAULT_GAIN_WIDTH
) (
   input  logic                                           in_clk,
   input  logic                                           in_reset_n,
   input  logic                                           in_enable,
   input  logic [2**MAXIMUM_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] in_variables_enable,
   input  logic signed [GAIN_WIDTH-1:0]                   in_gain,
   output logic [MAXIMUM_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] out_gain_read_index,
   output logic [MAXIMUM_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] out_best_variable_index,
   output logic signed [GAIN_WIDTH-1:0]                   out_best_gain,
   output logic                                           out_found,
   output logic                                           out_done
);

   localparam int IW = MAXIMUM_BIT_WIDTH_OF_VARIABLES_INDEX;
   localparam logic [IW-1:0] LAST_IDX = '1;

   state_e                       state_q, state_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic [IW-1:0]                best_idx_q, best_idx_d;
   logic signed [GAIN_WIDTH-1:0] best_gain_q, best_gain_d;
   logic                         found_q, found_d;
   logic                         done_q, done_d;
   logic                         update;

   stochastic_gain_compare #(
      .GAIN_WIDTH (GAIN_WIDTH)
   ) u_compare (
      .enable_bit_i (in_variables_enable[idx_q]),
      .found_i      (found_q),
      .gain_i       (in_gain),
      .best_gain_i  (best_gain_q),
      .update_o     (update)
   );

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no path through the case infers a latch.
      state_d     = state_q;
      idx_d       = idx_q;
      best_idx_d  = best_idx_q;
      best_gain_d = best_gain_q;
      found_d     = found_q;
      done_d      = done_q;

      case (state_q)
         ST_IDLE: begin
            if (in_enable) begin
               state_d     = ST_SCAN;
               idx_d       = '0;
               best_idx_d  = '0;
               best_gain_d = '0;
               found_d     = 1'b0;
               done_d      = 1'b0;
            end
         end
         ST_SCAN: begin
            if (!in_enable) begin
               // Abort discards the partial search entirely.
               state_d     = ST_IDLE;
               idx_d       = '0;
               best_idx_d  = '0;
               best_gain_d = '0;
               found_d     = 1'b0;
               done_d      = 1'b0;
            end else begin
               if (update) begin
                  best_idx_d  = idx_q;
                  best_gain_d = in_gain;
                  found_d     = 1'b1;
               end
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         ST_DONE: begin
            if (!in_enable) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         best_idx_q  <= '0;
         best_gain_q <= '0;
         found_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         best_idx_q  <= best_idx_d;
         best_gain_q <= best_gain_d;
         found_q     <= found_d;
         done_q      <= done_d;
      end
   end

   assign out_gain_read_index     = idx_q;
   assign out_best_variable_index = best_idx_q;
   assign out_best_gain           = best_gain_q;
   assign out_found               = found_q;
   assign out_done                = done_q;

endmodule : stochastic_best_gain_finder

// File: tb/tb_stochastic_best_gain_finder.sv
// Directed self-checking bench for stochastic_best_gain_finder with N=4, 8-bit gains.
module tb_stochastic_best_gain_finder;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] mask;
   logic [7:0] in_gain;
   logic [1:0] rd_idx;
   logic [1:0] best_idx;
   logic [7:0] best_gain;
   logic       found;
   logic       done;

   logic [7:0] gains [4];
   int         total;
   int         bad;

   // External gain storage, read combinationally at the scanned index.
   assign in_gain = gains[rd_idx];

   stochastic_best_gain_finder #(
      .MAXIMUM_BIT_WIDTH_OF_VARIABLES_INDEX (2),
      .GAIN_WIDTH                           (8)
   ) dut (
      .in_clk                  (clk),
      .in_reset_n              (rst_n),
      .in_enable               (en),
      .in_variables_enable     (mask),
      .in_gain                 (in_gain),
      .out_gain_read_index     (rd_idx),
      .out_best_variable_index (best_idx),
      .out_best_gain           (best_gain),
      .out_found               (found),
      .out_done                (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_found"}, 32'(found), 32'd0);
      check({tag, "_idx"}, 32'(best_idx), 32'd0);
      check({tag, "_gain"}, 32'(best_gain), 32'd0);
      check({tag, "_rd"}, 32'(rd_idx), 32'd0);
   endtask

   // Runs one search from IDLE; expects done exactly 5 edges after enable is first sampled.
   task automatic run_search(input string tag, input logic [3:0] m,
                             input logic [7:0] g0, input logic [7:0] g1,
                             input logic [7:0] g2, input logic [7:0] g3,
                             input logic [1:0] e_idx, input logic [7:0] e_gain, input logic e_found,
                             input bit drop_after);
      int edges;
      gains[0] = g0; gains[1] = g1; gains[2] = g2; gains[3] = g3;
      mask  = m;
      en    = 1'b1;
      edges = 0;
      while (!done && edges < 12) begin
         step();
         edges++;
         if (!done) check({tag, "_scan_rd"}, 32'(rd_idx), 32'(edges - 1));
      end
      check({tag, "_latency"}, 32'(edges), 32'd5);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_idx"}, 32'(best_idx), 32'(e_idx));
      check({tag, "_gain"}, 32'(best_gain), 32'(e_gain));
      check({tag, "_found"}, 32'(found), 32'(e_found));
      check({tag, "_rd_done"}, 32'(rd_idx), 32'd0);
      if (drop_after) begin
         step();
         check({tag, "_hold_done"}, 32'(done), 32'd1);
         check({tag, "_hold_gain"}, 32'(best_gain), 32'(e_gain));
         en = 1'b0;
         step();
         check({tag, "_idle_done"}, 32'(done), 32'd0);
         check({tag, "_idle_gain"}, 32'(best_gain), 32'(e_gain));
         check({tag, "_idle_idx"}, 32'(best_idx), 32'(e_idx));
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      en    = 1'b0;
      mask  = 4'b0000;
      for (int i = 0; i < 4; i++) gains[i] = 8'h00;

      #2;
      check_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      check_zero("idle_no_enable");

      run_search("basic", 4'b1111, 8'd3, 8'hFE, 8'd7, 8'd5, 2'd2, 8'd7, 1'b1, 1'b1);
      run_search("tie", 4'b1111, 8'd5, 8'd5, 8'd1, 8'd5, 2'd0, 8'd5, 1'b1, 1'b1);
      run_search("masked", 4'b1010, 8'd9, 8'hFC, 8'd9, 8'hFF, 2'd3, 8'hFF, 1'b1, 1'b1);
      run_search("most_neg", 4'b0100, 8'd100, 8'd50, 8'h80, 8'd127, 2'd2, 8'h80, 1'b1, 1'b1);
      run_search("empty", 4'b0000, 8'd10, 8'd20, 8'd30, 8'd40, 2'd0, 8'd0, 1'b0, 1'b1);

      // Mask narrowed after index 1 is scanned: only indices 0 and 1 remain in play.
      gains[0] = 8'd1; gains[1] = 8'd2; gains[2] = 8'd3; gains[3] = 8'd4;
      mask = 4'b1111;
      en   = 1'b1;
      step();
      step();
      step();
      mask = 4'b0011;
      step();
      step();
      check("midmask_done", 32'(done), 32'd1);
      check("midmask_idx", 32'(best_idx), 32'd1);
      check("midmask_gain", 32'(best_gain), 32'd2);
      en = 1'b0;
      step();

      // Abort after two scan edges.
      gains[0] = 8'd3; gains[1] = 8'hFE; gains[2] = 8'd7; gains[3] = 8'd5;
      mask = 4'b1111;
      en   = 1'b1;
      step();
      step();
      step();
      check("abort_mid_found", 32'(found), 32'd1);
      check("abort_mid_gain", 32'(best_gain), 32'd3);
      en = 1'b0;
      step();
      check_zero("abort");
      for (int i = 0; i < 4; i++) begin
         step();
         check("abort_no_done", 32'(done), 32'd0);
      end
      run_search("after_abort", 4'b1111, 8'd3, 8'hFE, 8'd7, 8'd5, 2'd2, 8'd7, 1'b1, 1'b1);

      // Asynchronous reset while in DONE, enable kept high throughout.
      run_search("pre_reset", 4'b1001, 8'h80, 8'd0, 8'd0, 8'h81, 2'd3, 8'h81, 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      #1 rst_n = 1'b1;
      run_search("post_reset", 4'b1001, 8'h80, 8'd0, 8'd0, 8'h81, 2'd3, 8'h81, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_stochastic_best_gain_finder
